countdown_controller: RTL and testbench
=======================================

COUNTDOWN_CONTROLLER -- requirements
Module: countdown_controller

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 start  input  1  request to load load_value and begin a countdown, honoured only in IDLE.
REQ-004 load_value  input  32  unsigned countdown length N, sampled on the start edge.
REQ-005 pause  input  1  while high in RUN, count holds.
REQ-006 abort  input  1  terminate the countdown and return to IDLE.
REQ-007 count  output  32  current countdown register.
REQ-008 zero  output  1  combinational, high when count equals 0; produced by the team's 32-bit zero-checker block instantiated on count.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  high for exactly the cycles spent in DONE.

Function
REQ-011 The FSM SHALL have three states, IDLE, RUN and DONE, with a 2-bit encoding and no other reachable state.
REQ-012 In IDLE with start=1, the edge SHALL load count<=load_value and go to RUN when load_value!=0, or to DONE when load_value==0.
REQ-013 In IDLE with start=0, count SHALL hold and the state SHALL remain IDLE.
REQ-014 In IDLE, abort SHALL be ignored; start+abort in the same IDLE cycle SHALL start normally.
REQ-015 In RUN with abort=1, the edge SHALL clear count to 0 and go to IDLE, with no done cycle; abort has priority over pause.
REQ-016 In RUN with pause=1 and abort=0, count and state SHALL hold.
REQ-017 In RUN with pause=0 and abort=0, the edge SHALL set count<=count-1, going to DONE when the result is 0 (count was 1) and otherwise staying in RUN.
REQ-018 Latency: after a start edge with value N, done SHALL first be high after exactly N+1 rising edges (pause cycles add one each); N=0 gives done after 1 edge.
REQ-019 start SHALL be ignored while busy=1; load_value is not re-sampled.
REQ-020 count SHALL never wrap below 0; decrement occurs only in RUN, where count>=1.
REQ-021 DONE without the configuration macro: the next edge SHALL go to IDLE with count=0, ignoring start, pause and abort in that cycle.

Reset
REQ-022 When reset=1 at a rising edge, the block SHALL enter IDLE with count=0; busy=0, done=0 and zero=1 from the following cycle.
REQ-023 reset SHALL override start, abort and pause in any state, including mid-RUN and DONE.

Configuration
REQ-024 With macro COUNTDOWN_AUTO_RELOAD_EN defined, a 32-bit reload register SHALL capture load_value on every accepted start and be cleared by reset.
REQ-025 Under COUNTDOWN_AUTO_RELOAD_EN, DONE with abort=0 SHALL set count<=reload, going to RUN if reload!=0 or staying in DONE if reload==0; this gives a done pulse every N+1 cycles, or done held high for N=0.
REQ-026 Under COUNTDOWN_AUTO_RELOAD_EN, DONE with abort=1 SHALL go to IDLE with count=0.
REQ-027 Without COUNTDOWN_AUTO_RELOAD_EN, no reload register SHALL exist and REQ-021 SHALL apply.

Verification
REQ-028 reset, then start=1 with load_value=3 for one cycle -> count reads 3,2,1,0 on successive edges; done=1 for exactly one cycle after edge 4; busy=1 over edges 1-4; then IDLE.
REQ-029 start with load_value=0 -> done=1 after edge 1, busy=1 for one cycle, zero=1 throughout.
REQ-030 load_value=5, pause=1 for 2 cycles mid-RUN -> count holds for 2 edges; done after edge 8.
REQ-031 load_value=10, abort at count=6 while pause=1 -> next edge count=0, IDLE, done never asserted; a start held during RUN is not accepted.
REQ-032 load_value=4, reset asserted at count=2 -> next edge IDLE, count=0, done=0; a start in the same cycle as reset is not accepted.
REQ-033 COUNTDOWN_AUTO_RELOAD_EN defined, load_value=2 -> done pulses every 3 cycles until abort, then IDLE with count=0; with macro undefined, a single done pulse only.

Source files
------------

// File: rtl/countdown_controller_if.sv
// Handshake/status bundle for countdown_controller.
// master: the block issuing start/pause/abort; slave: the countdown controller.
interface countdown_controller_if;
    logic        start;
    logic [31:0] load_value;
    logic        pause;
    logic        abort;
    logic [31:0] count;
    logic        zero;
    logic        busy;
    logic        done;

    modport master (
        output start, load_value, pause, abort,
        input  count, zero, busy, done
    );

    modport slave (
        input  start, load_value, pause, abort,
        output count, zero, busy, done
    );
endinterface

// File: rtl/countdown_controller.sv
// Countdown controller: IDLE -> RUN -> DONE -> IDLE, with pause/abort control.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to make DONE reload the
// last accepted load_value and keep counting instead of returning to IDLE.

// 32-bit zero detector shared across blocks.
module zero_check32 (
    input  logic [31:0] value_i,
    output logic        zero_o
);
    assign zero_o = ~|value_i;
endmodule

module countdown_controller (
    input  logic                   clk,
    input  logic                   reset,
    countdown_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic        busy_q;
    logic        done_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [31:0] reload_q, reload_d;
`endif

    // Next-state and next-count; RUN only decrements when count >= 1, so no wrap.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            S_IDLE: begin
                // abort is ignored here; start wins even when abort is high
                if (bus.start) begin
                    count_d  = bus.load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    reload_d = bus.load_value;
`endif
                    state_d  = (bus.load_value == 32'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    count_d = 32'd0;
                    state_d = S_IDLE;
                end else if (!bus.pause) begin
                    count_d = count_q - 32'd1;
                    if (count_q == 32'd1) state_d = S_DONE;
                end
            end
            S_DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (bus.abort) begin
                    count_d = 32'd0;
                    state_d = S_IDLE;
                end else begin
                    count_d = reload_q;
                    state_d = (reload_q == 32'd0) ? S_DONE : S_RUN;
                end
`else
                count_d = 32'd0;
                state_d = S_IDLE;
`endif
            end
            default: begin
                count_d = 32'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, count and registered busy/done flags; reset overrides all controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    zero_check32 u_zero (
        .value_i (count_q),
        .zero_o  (bus.zero)
    );

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_countdown_controller.sv
// Self-checking bench for countdown_controller: directed scenarios plus
// randomized control traffic compared against a behavioural model.
module tb_countdown_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    countdown_controller_if bus();

    countdown_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: remaining count plus "active" and "finished" flags.
    logic [31:0] m_cnt  = 32'd0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [31:0] m_reload = 32'd0;
`endif

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_busy = 0; m_done = 0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            m_reload = 0;
`endif
        end else if (!m_busy) begin
            if (bus.start) begin
                m_cnt  = bus.load_value;
                m_busy = 1;
                m_done = (bus.load_value == 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                m_reload = bus.load_value;
`endif
            end
        end else if (m_done) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (bus.abort) begin
                m_cnt = 0; m_busy = 0; m_done = 0;
            end else begin
                m_cnt  = m_reload;
                m_done = (m_reload == 0);
            end
`else
            m_cnt = 0; m_busy = 0; m_done = 0;
`endif
        end else begin
            if (bus.abort) begin
                m_cnt = 0; m_busy = 0;
            end else if (!bus.pause) begin
                m_cnt  = m_cnt - 1;
                m_done = (m_cnt == 0);
            end
        end
    end

    // One clock: drive at the falling edge, let a rising edge pass, sample at the next fall.
    task automatic cyc(input bit s, input logic [31:0] lv, input bit p, input bit a, input bit r);
        bus.start = s; bus.load_value = lv; bus.pause = p; bus.abort = a; reset = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(1, 32'd9, 1, 1, 1);
        cyc(1, 32'd9, 1, 1, 1);
        n_tests++;
        if (bus.count !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: count=%0d busy=%b done=%b zero=%b, want 0/0/0/1",
                     bus.count, bus.busy, bus.done, bus.zero);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ec[4] = '{32'd3, 32'd2, 32'd1, 32'd0};
        bit          ed[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        cyc(0, 0, 0, 0, 1);
        cyc(1, 32'd3, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc(0, 32'd77, 0, 0, 0);
            n_tests++;
            if (bus.count !== ec[i] || bus.done !== ed[i] || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic edge%0d: count=%0d done=%b busy=%b, want count=%0d done=%b busy=1",
                         i + 1, bus.count, bus.done, bus.busy, ec[i], ed[i]);
            end
        end
        cyc(0, 0, 0, 0, 0);
        n_tests++;
        if ({bus.count, bus.zero, bus.busy, bus.done} !== {m_cnt, (m_cnt == 0), m_busy, m_done}) begin
            n_fail++;
            $display("FAIL basic edge5: count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                     bus.count, bus.busy, bus.done, m_cnt, m_busy, m_done);
        end
    endtask

    task automatic test_zero_len();
        cyc(0, 0, 0, 0, 1);
        cyc(1, 32'd0, 0, 0, 0);
        n_tests++;
        if (bus.count !== 32'd0 || bus.zero !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_len edge1: count=%0d zero=%b busy=%b done=%b, want 0/1/1/1",
                     bus.count, bus.zero, bus.busy, bus.done);
        end
        cyc(0, 0, 0, 0, 0);
        n_tests++;
        if (bus.zero !== 1'b1 || bus.busy !== m_busy || bus.done !== m_done) begin
            n_fail++;
            $display("FAIL zero_len edge2: zero=%b busy=%b done=%b, want zero=1 busy=%b done=%b",
                     bus.zero, bus.busy, bus.done, m_busy, m_done);
        end
    endtask

    task automatic test_pause();
        int edges = 1;
        int first = 0;
        bit p;
        cyc(0, 0, 0, 0, 1);
        cyc(1, 32'd5, 0, 0, 0);
        while (first == 0 && edges < 20) begin
            p = (edges == 2 || edges == 3);
            cyc(0, 0, p, 0, 0);
            edges++;
            if (edges == 3 || edges == 4) begin
                n_tests++;
                if (bus.count !== 32'd4) begin
                    n_fail++;
                    $display("FAIL pause hold edge%0d: count=%0d, want 4", edges, bus.count);
                end
            end
            if (bus.done === 1'b1) first = edges;
        end
        n_tests++;
        if (first !== 8) begin
            n_fail++;
            $display("FAIL pause latency: first done at edge %0d, want 8", first);
        end
    endtask

    task automatic test_abort();
        bit saw_done = 0;
        cyc(0, 0, 0, 0, 1);
        cyc(1, 32'd10, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'd99, 0, 0, 0);
            if (bus.done === 1'b1) saw_done = 1;
        end
        n_tests++;
        if (bus.count !== 32'd6) begin
            n_fail++;
            $display("FAIL abort pre: count=%0d, want 6 (start during RUN must be ignored)", bus.count);
        end
        cyc(1, 32'd99, 1, 1, 0);
        if (bus.done === 1'b1) saw_done = 1;
        n_tests++;
        if (bus.count !== 32'd0 || bus.busy !== 1'b0 || saw_done) begin
            n_fail++;
            $display("FAIL abort: count=%0d busy=%b saw_done=%b, want 0/0/0", bus.count, bus.busy, saw_done);
        end
        cyc(0, 0, 0, 1, 0);
        n_tests++;
        if (bus.count !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort idle: count=%0d busy=%b done=%b, want 0/0/0", bus.count, bus.busy, bus.done);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 0, 0, 1);
        cyc(1, 32'd4, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        n_tests++;
        if (bus.count !== 32'd2) begin
            n_fail++;
            $display("FAIL reset_mid pre: count=%0d, want 2", bus.count);
        end
        cyc(1, 32'd7, 0, 0, 1);
        n_tests++;
        if (bus.count !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: count=%0d busy=%b done=%b zero=%b, want 0/0/0/1",
                     bus.count, bus.busy, bus.done, bus.zero);
        end
        cyc(0, 0, 0, 0, 0);
        n_tests++;
        if (bus.count !== 32'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid after: count=%0d busy=%b, want 0/0", bus.count, bus.busy);
        end
    endtask

    task automatic test_reload();
        cyc(0, 0, 0, 0, 1);
        cyc(1, 32'd2, 0, 0, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        for (int e = 2; e <= 10; e++) begin
            cyc(0, 0, 0, 0, 0);
            n_tests++;
            if (bus.done !== (e % 3 == 0)) begin
                n_fail++;
                $display("FAIL reload edge%0d: done=%b, want %b", e, bus.done, (e % 3 == 0));
            end
        end
        cyc(0, 0, 0, 1, 0);
        n_tests++;
        if (bus.count !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reload abort: count=%0d busy=%b done=%b, want 0/0/0", bus.count, bus.busy, bus.done);
        end
`else
        begin
            int pulses = 0;
            int at = 0;
            for (int e = 2; e <= 10; e++) begin
                cyc(0, 0, 0, 0, 0);
                if (bus.done === 1'b1) begin pulses++; at = e; end
            end
            n_tests++;
            if (pulses != 1 || at != 3 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL single pulse: pulses=%0d at edge %0d busy=%b, want 1 at edge 3, busy=0",
                         pulses, at, bus.busy);
            end
        end
`endif
    endtask

    task automatic test_random();
        bit s, p, a, r;
        logic [31:0] lv;
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 3) == 0);
            p  = ($urandom_range(0, 4) == 0);
            a  = ($urandom_range(0, 24) == 0);
            lv = ($urandom_range(0, 19) == 0) ? 32'($urandom) : 32'($urandom_range(0, 6));
            cyc(s, lv, p, a, r);
            n_tests++;
            if ({bus.count, bus.zero, bus.busy, bus.done} !== {m_cnt, (m_cnt == 0), m_busy, m_done}) begin
                n_fail++;
                $display("FAIL random cyc%0d: got cnt=%0d z=%b b=%b d=%b, want cnt=%0d z=%b b=%b d=%b",
                         i, bus.count, bus.zero, bus.busy, bus.done, m_cnt, (m_cnt == 0), m_busy, m_done);
            end
        end
    endtask

    initial begin
        bus.start = 0; bus.load_value = 0; bus.pause = 0; bus.abort = 0;
        test_reset();
        test_basic();
        test_zero_len();
        test_pause();
        test_abort();
        test_reset_mid();
        test_reload();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, tests run %0d", n_tests);
        $fatal(1, "timeout");
    end
endmodule
